// File: rtl/expr_dispatch_if.sv
// Token, stack-strobe and calculation-controller signals of the expression dispatcher.
// The dispatcher is the slave; the upstream/stack/controller side is the master.
interface expr_dispatch_if #(
  parameter int unsigned W = 16
);
  logic         tok_valid;
  logic         tok_ready;
  logic [2:0]   tok_type;
  logic [W-1:0] tok_val;
  logic         num_push;
  logic [W-1:0] num_data;
  logic         op_push;
  logic [2:0]   op_data;
  logic         op_discard;
  logic [2:0]   op_top;
  logic         op_empty;
  logic         cal_start;
  logic         cal_complete;
  logic         expr_done;
  logic         expr_err;

  modport slave (
    input  tok_valid, tok_type, tok_val, op_top, op_empty, cal_complete,
    output tok_ready, num_push, num_data, op_push, op_data, op_discard,
           cal_start, expr_done, expr_err
  );

  modport master (
    output tok_valid, tok_type, tok_val, op_top, op_empty, cal_complete,
    input  tok_ready, num_push, num_data, op_push, op_data, op_discard,
           cal_start, expr_done, expr_err
  );
endinterface

// File: rtl/expr_dispatch.sv
// Infix token front end: pushes operands/operators and schedules reductions on the
// calculation controller using operator precedence and parentheses.
module expr_dispatch #(
  parameter int unsigned W       = 16,
  parameter int unsigned CNT_W   = 5,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic           clk,
  input  logic           reset,
  expr_dispatch_if.slave bus
);

  typedef enum logic [2:0] {
    T_NUM  = 3'd0,
    T_ADD  = 3'd1,
    T_SUB  = 3'd2,
    T_MUL  = 3'd3,
    T_DIV  = 3'd4,
    T_LPAR = 3'd5,
    T_RPAR = 3'd6,
    T_END  = 3'd7
  } tok_e;

  typedef enum logic [2:0] {
    S_ACCEPT,
    S_DECIDE,
    S_REDUCE,
    S_WAIT,
    S_DONE,
    S_ERR
  } state_e;

  localparam int unsigned     TMR_W    = $clog2(TIMEOUT + 1);
  // Leaving WAIT on the cycle the timer would reach TIMEOUT puts ERR TIMEOUT+1 cycles after cal_start.
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);

  state_e             state_q, state_d;
  tok_e               tok_type_q, tok_type_d;
  logic [W-1:0]       tok_val_q, tok_val_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [TMR_W-1:0]   tmr_q, tmr_d;
  logic               reduce_op;

  function automatic logic prec_hi(input logic [2:0] t);
    return (t == T_MUL) || (t == T_DIV);
  endfunction

  // prec(top) >= prec(tok): a high-precedence top always wins, a low one only against low.
  assign reduce_op = !bus.op_empty && (bus.op_top != T_LPAR) &&
                     (prec_hi(bus.op_top) || !prec_hi(tok_type_q));

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_ACCEPT;
      tok_type_q <= T_NUM;
      tok_val_q  <= '0;
      cnt_q      <= '0;
      tmr_q      <= '0;
    end else begin
      state_q    <= state_d;
      tok_type_q <= tok_type_d;
      tok_val_q  <= tok_val_d;
      cnt_q      <= cnt_d;
      tmr_q      <= tmr_d;
    end
  end

  assign bus.num_data = tok_val_q;
  assign bus.op_data  = tok_type_q;

  always_comb begin
    state_d        = state_q;
    tok_type_d     = tok_type_q;
    tok_val_d      = tok_val_q;
    cnt_d          = cnt_q;
    tmr_d          = tmr_q;
    bus.tok_ready  = 1'b0;
    bus.num_push   = 1'b0;
    bus.op_push    = 1'b0;
    bus.op_discard = 1'b0;
    bus.cal_start  = 1'b0;
    bus.expr_done  = 1'b0;
    bus.expr_err   = 1'b0;

    unique case (state_q)
      S_ACCEPT: begin
        bus.tok_ready = !reset;
        if (bus.tok_valid) begin
          tok_type_d = tok_e'(bus.tok_type);
          tok_val_d  = bus.tok_val;
          state_d    = S_DECIDE;
        end
      end

      S_DECIDE: begin
        unique case (tok_type_q)
          T_NUM: begin
            bus.num_push = 1'b1;
            cnt_d        = cnt_q + 1'b1;
            state_d      = S_ACCEPT;
          end
          T_LPAR: begin
            bus.op_push = 1'b1;
            state_d     = S_ACCEPT;
          end
          T_ADD, T_SUB, T_MUL, T_DIV: begin
            if (reduce_op) begin
              state_d = S_REDUCE;
            end else begin
              bus.op_push = 1'b1;
              state_d     = S_ACCEPT;
            end
          end
          T_RPAR: begin
            if (bus.op_empty) begin
              state_d = S_ERR;
            end else if (bus.op_top == T_LPAR) begin
              bus.op_discard = 1'b1;
              state_d        = S_ACCEPT;
            end else begin
              state_d = S_REDUCE;
            end
          end
          T_END: begin
            if (!bus.op_empty && bus.op_top == T_LPAR) begin
              state_d = S_ERR;
            end else if (bus.op_empty) begin
              state_d = (cnt_q == CNT_W'(1)) ? S_DONE : S_ERR;
            end else begin
              state_d = S_REDUCE;
            end
          end
          default: state_d = S_ERR;
        endcase
      end

      S_REDUCE: begin
        if (cnt_q < CNT_W'(2)) begin
          state_d = S_ERR;
        end else begin
          bus.cal_start = 1'b1;
          cnt_d         = cnt_q - 1'b1;
          tmr_d         = '0;
          state_d       = S_WAIT;
        end
      end

      S_WAIT: begin
        if (bus.cal_complete) begin
          state_d = S_DECIDE;
        end else begin
          tmr_d = tmr_q + 1'b1;
          if (tmr_q == TMR_LAST) begin
            state_d = S_ERR;
          end
        end
      end

      S_DONE: begin
        bus.expr_done = 1'b1;
        cnt_d         = '0;
        state_d       = S_ACCEPT;
      end

      S_ERR: begin
        bus.expr_err = 1'b1;
      end

      default: state_d = S_ACCEPT;
    endcase
  end

endmodule
